// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from an upstream FIFO and sends them as 8N1-style UART frames.
// Optional even parity bit between payload and stop bit when FIFO_UART_TX_PARITY_EN is defined.
// Frame: start(0), DATA_W payload bits LSB first, [parity], stop(1); each CLKS_PER_BIT cycles.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic [15:0]       frame_cnt
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  baud_q, baud_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_d;
    logic              baud_last;
    logic              frame_done;

    assign baud_last = (baud_q == BAUD_LAST);

    // Strobe and status decoded purely from registered state.
    assign fifo_rd = (state_q == POP);
    assign busy    = (state_q != IDLE);

`ifdef FIFO_UART_TX_PARITY_EN
    logic parity_q;

    // Even parity of the word captured alongside the shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (state_q == LOAD) begin
            parity_q <= ^fifo_data;
        end
    end
`endif

    // Next-state, baud/bit counters and shift register update.
    always_comb begin
        state_d    = state_q;
        baud_d     = '0;
        idx_d      = idx_q;
        shift_d    = shift_q;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && !fifo_empty) state_d = POP;
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d = fifo_data;
                idx_d   = '0;
                state_d = START;
            end
            START: begin
                if (baud_last) state_d = DATA;
                else           baud_d  = baud_q + 1'b1;
            end
            DATA: begin
                if (baud_last) begin
                    if (idx_q == IDX_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) state_d = STOP;
                else           baud_d  = baud_q + 1'b1;
            end
`endif
            STOP: begin
                if (baud_last) begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level for the upcoming cycle, registered so tx is glitch-free.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:  tx_d = 1'b0;
            DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: tx_d = parity_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // State, counters, shift register and registered line output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx      <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx      <= tx_d;
        end
    end

    // Completed-frame counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 16'd0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed self-checking bench for fifo_uart_tx (CLKS_PER_BIT=4, DATA_W=8).
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_rd;
    logic        tx;
    logic        busy;
    logic [15:0] frame_cnt;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rd_count = 0;
    int pop_q[$];

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd   (fifo_rd),
        .tx        (tx),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    // Count pop strobes and log the cycle each one is seen in.
    always @(posedge clk) begin
        if (fifo_rd === 1'b1) begin
            rd_count++;
            pop_q.push_back(cyc);
        end
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for frame bit b of word d.
    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef FIFO_UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic wait_pop(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_rd === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Wait for the pop, supply the word, then check every cycle of the frame.
    task automatic frame(input logic [7:0] d, input bit last, input bit drop_en);
        bit ok;
        wait_pop(ok);
        check("pop_seen", {31'd0, ok}, 32'd1);
        if (!ok) return;
        fifo_data = d;
        if (last) fifo_empty = 1'b1;
        @(negedge clk);
        check("load_tx", {31'd0, tx}, 32'd1);
        check("load_rd", {31'd0, fifo_rd}, 32'd0);
        for (int b = 0; b < FRAME_BITS; b++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (drop_en && b == 3) en = 1'b0;
                check($sformatf("tx_%02h_b%0d_c%0d", d, b, c), {31'd0, tx}, {31'd0, exp_bit(d, b)});
            end
            check($sformatf("busy_%02h_b%0d", d, b), {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        check("end_busy", {31'd0, busy}, 32'd0);
        check("end_tx", {31'd0, tx}, 32'd1);
    endtask

    initial begin
        bit ok;
        int rd_before;
        int pops_before;
        int en_cyc;
        int txlow;

        rst = 1'b1;
        en = 1'b0;
        fifo_empty = 1'b1;
        fifo_data = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd", {31'd0, fifo_rd}, 32'd0);
        check("rst_cnt", {16'd0, frame_cnt}, 32'd0);
        rst = 1'b0;

        // No pop with en=0, nor with an empty FIFO
        fifo_empty = 1'b0;
        repeat (6) @(negedge clk);
        check("en0_rd", rd_count, 32'd0);
        check("en0_busy", {31'd0, busy}, 32'd0);
        en = 1'b1;
        fifo_empty = 1'b1;
        repeat (6) @(negedge clk);
        check("empty_rd", rd_count, 32'd0);
        check("empty_tx", {31'd0, tx}, 32'd1);

        // Single byte 0xA5
        fifo_empty = 1'b0;
        frame(8'hA5, 1'b1, 1'b0);
        check("a5_cnt", {16'd0, frame_cnt}, 32'd1);
        check("a5_rd", rd_count, 32'd1);

        // 0x01 (odd weight, parity bit 1 when enabled)
        fifo_empty = 1'b0;
        frame(8'h01, 1'b1, 1'b0);
        check("01_cnt", {16'd0, frame_cnt}, 32'd2);

        // Three back-to-back bytes
        pops_before = pop_q.size();
        fifo_empty = 1'b0;
        frame(8'h00, 1'b0, 1'b0);
        frame(8'hFF, 1'b0, 1'b0);
        frame(8'h3C, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("b2b_pops", pop_q.size() - pops_before, 32'd3);
        if (pop_q.size() - pops_before == 3) begin
            check("b2b_gap1", pop_q[pops_before+1] - pop_q[pops_before], FRAME_BITS * CPB + 3);
            check("b2b_gap2", pop_q[pops_before+2] - pop_q[pops_before+1], FRAME_BITS * CPB + 3);
        end
        check("b2b_cnt", {16'd0, frame_cnt}, 32'd5);

        // en dropped mid-frame with a second word pending
        fifo_empty = 1'b0;
        frame(8'h12, 1'b0, 1'b1);
        rd_before = rd_count;
        repeat (8) @(negedge clk);
        check("endrop_cnt", {16'd0, frame_cnt}, 32'd6);
        check("endrop_rd", rd_count, rd_before);
        check("endrop_busy", {31'd0, busy}, 32'd0);
        en = 1'b1;
        en_cyc = cyc;
        frame(8'h34, 1'b1, 1'b0);
        check("enrise_lat", pop_q[pop_q.size()-1] - en_cyc, 32'd1);
        check("enrise_cnt", {16'd0, frame_cnt}, 32'd7);

        // Reset during DATA bit 3
        fifo_data = 8'h00;
        fifo_empty = 1'b0;
        wait_pop(ok);
        check("rstmid_pop", {31'd0, ok}, 32'd1);
        fifo_empty = 1'b1;
        repeat (19) @(negedge clk);
        check("rstmid_pre_tx", {31'd0, tx}, 32'd0);
        check("rstmid_pre_busy", {31'd0, busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rstmid_tx", {31'd0, tx}, 32'd1);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_rd", {31'd0, fifo_rd}, 32'd0);
        repeat (2) @(negedge clk);
        check("rstmid_cnt", {16'd0, frame_cnt}, 32'd0);
        rd_before = rd_count;
        rst = 1'b0;
        txlow = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) txlow++;
        end
        check("post_rst_txlow", txlow, 32'd0);
        check("post_rst_rd", rd_count, rd_before);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // Counter wrap: preload 0xFFFF, send one frame
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        @(negedge clk);
        check("wrap_pre", {16'd0, frame_cnt}, 32'h0000FFFF);
        fifo_empty = 1'b0;
        frame(8'h5A, 1'b1, 1'b0);
        check("wrap_cnt", {16'd0, frame_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit; legal range 2..65535.
REQ-002 The block SHALL have parameter DATA_W, default 8, width of the FIFO data word and of the serial payload.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port en  input  1  permits starting new frames.
REQ-006 The block SHALL have port fifo_empty  input  1  upstream FIFO has no data.
REQ-007 The block SHALL have port fifo_data  input  DATA_W  upstream FIFO registered read data, valid the cycle after a read strobe.
REQ-008 The block SHALL have port fifo_rd  output  1  one-cycle pop strobe to the upstream FIFO.
REQ-009 The block SHALL have port tx  output  1  serial line, idle high.
REQ-010 The block SHALL have port busy  output  1  high in every state other than IDLE.
REQ-011 The block SHALL have port frame_cnt  output  16  count of completed frames, wraps 0xFFFF->0.

Function
REQ-012 The FSM SHALL have the states IDLE, POP, LOAD, START, DATA, PARITY, STOP.
REQ-013 IDLE->POP SHALL occur on the clock edge where en=1 and fifo_empty=0; otherwise the FSM SHALL remain in IDLE.
REQ-014 fifo_rd SHALL be 1 only while in POP, exactly one cycle per frame, and SHALL be decoded from registered state with no combinational path from the inputs.
REQ-015 POP->LOAD SHALL be unconditional; in LOAD the block SHALL capture fifo_data into the shift register, then go LOAD->START.
REQ-016 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-017 DATA SHALL shift out DATA_W bits LSB first, each held CLKS_PER_BIT cycles; a bit index counter SHALL select DATA->PARITY (macro defined) or DATA->STOP after the last bit.
REQ-018 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then go to IDLE and increment frame_cnt by 1 on that same edge.
REQ-019 The baud counter SHALL count 0..CLKS_PER_BIT-1, reload to 0 on every state entry, and be sized $clog2(CLKS_PER_BIT).
REQ-020 tx SHALL be a registered output, 1 in IDLE, POP and LOAD.
REQ-021 Deasserting en mid-frame SHALL NOT abort the frame; it only blocks the next IDLE->POP.
REQ-022 The spacing between the start bits of back-to-back frames SHALL be exactly frame_bits*CLKS_PER_BIT+3 cycles: IDLE, POP and LOAD, one cycle each.
REQ-023 fifo_empty SHALL be ignored outside IDLE; a frame SHALL never pop more than once.

Reset
REQ-024 While rst=1: state=IDLE, tx=1, fifo_rd=0, busy=0, frame_cnt=0, baud counter, bit index and shift register = 0.
REQ-025 Reset asserted mid-frame SHALL force tx=1 immediately (asynchronously); the popped byte SHALL be discarded and never retransmitted.
REQ-026 After rst deasserts, the first pop SHALL occur no earlier than the first rising edge with en=1 and fifo_empty=0.

Configuration
REQ-027 With macro FIFO_UART_TX_PARITY_EN defined, the PARITY state SHALL send one even-parity bit (XOR of the payload) for CLKS_PER_BIT cycles between DATA and STOP, and frame_bits SHALL be DATA_W+3.
REQ-028 Without FIFO_UART_TX_PARITY_EN, no PARITY state or parity logic SHALL exist, and frame_bits SHALL be DATA_W+2.

Verification (CLKS_PER_BIT=4, DATA_W=8)
REQ-029 Single byte 0xA5, no parity: fifo_rd pulses 1 cycle, then tx = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, 40 cycles total; frame_cnt 0->1.
REQ-030 0xA5 with PARITY_EN: tx = 0,1,0,1,0,0,1,0,1,0(parity),1, 44 cycles total; 0x01 yields parity bit 1.
REQ-031 Three queued bytes 0x00,0xFF,0x3C with fifo_empty=0 throughout: start-bit falling edges exactly 43 cycles apart, exactly 3 fifo_rd pulses, frame_cnt=3.
REQ-032 en dropped in the middle of frame 1 of two queued bytes: frame 1 completes, no second fifo_rd while en=0; en=1 -> POP on the next edge.
REQ-033 rst asserted during DATA bit 3: tx=1 and busy=0 in the same cycle; after release with fifo_empty=1, tx stays 1 and no fifo_rd pulses.
REQ-034 frame_cnt preloaded by sending 65535 frames, then 1 more: frame_cnt wraps to 0x0000.
